// File: rtl/config_frame_writer.sv
// config_frame_writer
// Takes a stream of words. An address word (MSB set) selects a start frame
// IDX and a burst length N = CNT+1. The N data words that follow are each
// written to the column frame latches using a SETUP / STROBE / HOLD sequence.
// A burst that would run past the last frame is consumed and dropped, and err
// is flagged. A stray data word seen while idle is also dropped and flags err.
//
// Ports
//   CLK          rising-edge clock
//   reset        synchronous, active-high reset
//   s_data       stream word (address or frame data)
//   s_valid      s_data valid
//   s_ready      block accepts s_data this cycle
//   FrameData    registered data bus to the frame latches
//   FrameStrobe  registered one-hot latch enables
//   busy         state is not IDLE
//   done         registered one-cycle pulse at the end of a burst
//   err          sticky error flag
//   err_clr      clears err (a new error in the same cycle wins)
module config_frame_writer #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       err_clr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4,
    DISCARD   = 3'd5
  } state_t;

  localparam logic [9:0] LastFrame = 10'(MaxFramesPerCol - 1);

  state_t                     state;
  state_t                     next_state;
  logic [7:0]                 ptr;
  logic [8:0]                 remaining;
  logic                       xfer;
  logic                       marker;
  logic [7:0]                 cnt;
  logic [7:0]                 idx;
  logic                       in_range;
  logic                       err_set;
  logic [MaxFramesPerCol-1:0] onehot;

  assign busy = (state != IDLE);

  // Stream handshake, address-word decode and range check
  always_comb begin
    s_ready  = 1'b0;
    if (((state == IDLE) || (state == WAIT_DATA) || (state == DISCARD)) && !reset) begin
      s_ready = 1'b1;
    end else begin
      s_ready = 1'b0;
    end
    xfer     = s_valid & s_ready;
    marker   = s_data[FrameBitsPerRow-1];
    cnt      = s_data[15:8];
    idx      = s_data[7:0];
    // Widened to 10 bits so IDX+CNT cannot wrap before the compare
    in_range = (({2'b00, idx} + {2'b00, cnt}) <= LastFrame);
    onehot   = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << ptr;
  end

  // Next-state logic and error detection
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (!marker) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end else if (in_range) begin
            next_state = WAIT_DATA;
          end else begin
            err_set    = 1'b1;
            next_state = DISCARD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_DATA: begin
        if (xfer) begin
          next_state = SETUP;
        end else begin
          next_state = WAIT_DATA;
        end
      end
      SETUP:  next_state = STROBE;
      STROBE: next_state = HOLD;
      HOLD: begin
        if (remaining > 9'd1) begin
          next_state = WAIT_DATA;
        end else begin
          next_state = IDLE;
        end
      end
      DISCARD: begin
        if (xfer && (remaining == 9'd1)) begin
          next_state = IDLE;
        end else begin
          next_state = DISCARD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, burst bookkeeping and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 8'd0;
      remaining   <= 9'd0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= next_state;
      err         <= err_set | (err & ~err_clr);
      done        <= (state == HOLD) && (remaining == 9'd1);
      // Strobe is high only during the cycle following SETUP, i.e. STROBE
      FrameStrobe <= (state == SETUP) ? onehot : '0;
      case (state)
        IDLE: begin
          if (xfer && marker) begin
            ptr       <= idx;
            remaining <= {1'b0, cnt} + 9'd1;
          end
        end
        WAIT_DATA: begin
          if (xfer) begin
            FrameData <= s_data;
          end
        end
        HOLD: begin
          remaining <= remaining - 9'd1;
          ptr       <= ptr + 8'd1;
        end
        DISCARD: begin
          if (xfer) begin
            remaining <= remaining - 9'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer (default parameters 32/32).
// Stimulus pushes the expected strobe events and done pulses into queues. A
// monitor running on the falling edge pops and checks those queues whenever
// the DUT shows a strobe or a done pulse.
module tb_config_frame_writer;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [31:0] FrameStrobe;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr;

  config_frame_writer #(.MaxFramesPerCol(32), .FrameBitsPerRow(32)) dut (
    .CLK(CLK), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done),
    .err(err), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] strobe;
    logic [31:0] data;
    int          gap;    // required cycles since previous strobe, 0 = unchecked
    bit          after;  // check FrameData in the cycle after the strobe
  } exp_t;

  exp_t        exp_q[$];
  logic        done_q[$];  // expected err value at each done pulse
  int          tests  = 0;
  int          failed = 0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          last_strobe = 0;
  logic [31:0] prev_data = 32'h0;
  bit          after_pend = 1'b0;
  logic [31:0] after_data = 32'h0;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_strobe(input logic [31:0] strobe, input logic [31:0] data,
                            input int gap, input bit after);
    exp_t e;
    e.strobe = strobe;
    e.data   = data;
    e.gap    = gap;
    e.after  = after;
    exp_q.push_back(e);
  endtask

  // Call at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [31:0] w);
    int guard = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  // Monitor: compares every strobe and done pulse against the scoreboard
  always @(negedge CLK) begin
    cyc++;
    if (mon_en) begin
      if (after_pend) begin
        chk("data_after_strobe", FrameData, after_data);
        after_pend = 1'b0;
      end
      if (FrameStrobe !== 32'h0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", FrameStrobe, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe", FrameStrobe, mon_e.strobe);
          chk("data_at_strobe", FrameData, mon_e.data);
          chk("data_before_strobe", prev_data, mon_e.data);
          if (mon_e.gap > 0) chk("strobe_gap", 32'(cyc - last_strobe), 32'(mon_e.gap));
          after_pend = mon_e.after;
          after_data = mon_e.data;
        end
        last_strobe = cyc;
      end
      if (done !== 1'b0) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'h0, done}, 32'h0);
        end else begin
          chk("err_at_done", {31'h0, err}, {31'h0, done_q.pop_front()});
        end
      end
    end
    prev_data = FrameData;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    err_clr = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_strobe", FrameStrobe, 32'h0);
    chk("rst_data", FrameData, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, s_ready}, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", {31'h0, s_ready}, 32'h1);

    // Single frame at index 5
    exp_strobe(32'h0000_0020, 32'hDEADBEEF, 0, 1'b1);
    done_q.push_back(1'b0);
    send(32'h8000_0005);
    chk("busy_wait_data", {31'h0, busy}, 32'h1);
    send(32'hDEADBEEF);
    repeat (6) @(negedge CLK);
    chk("single_err", {31'h0, err}, 32'h0);
    chk("single_idle", {31'h0, busy}, 32'h0);
    chk("data_hold_idle", FrameData, 32'hDEADBEEF);

    // Burst IDX=29 N=3 ending at the last frame, continuous valid
    exp_strobe(32'h2000_0000, 32'hA5A5_0001, 0, 1'b1);
    exp_strobe(32'h4000_0000, 32'hA5A5_0002, 4, 1'b1);
    exp_strobe(32'h8000_0000, 32'hA5A5_0003, 4, 1'b1);
    done_q.push_back(1'b0);
    send(32'h8000_021D);
    send(32'hA5A5_0001);
    send(32'hA5A5_0002);
    send(32'hA5A5_0003);
    repeat (6) @(negedge CLK);
    chk("burst_idle", {31'h0, busy}, 32'h0);

    // Overrun IDX=31 N=2: both words discarded
    send(32'h8000_011F);
    chk("overrun_err", {31'h0, err}, 32'h1);
    chk("discard_busy", {31'h0, busy}, 32'h1);
    chk("discard_ready", {31'h0, s_ready}, 32'h1);
    send(32'h1111_1111);
    chk("discard_busy2", {31'h0, busy}, 32'h1);
    send(32'h2222_2222);
    chk("discard_end", {31'h0, busy}, 32'h0);
    chk("discard_data", FrameData, 32'hA5A5_0003);
    chk("discard_err", {31'h0, err}, 32'h1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("err_cleared", {31'h0, err}, 32'h0);

    // Stray data word in IDLE, then set-wins against err_clr
    send(32'h0000_1234);
    chk("stray_err", {31'h0, err}, 32'h1);
    chk("stray_idle", {31'h0, busy}, 32'h0);
    err_clr = 1'b1;
    send(32'h0000_0055);
    err_clr = 1'b0;
    chk("set_wins", {31'h0, err}, 32'h1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("err_cleared2", {31'h0, err}, 32'h0);
    exp_strobe(32'h0000_0001, 32'h1234_5678, 0, 1'b1);
    done_q.push_back(1'b0);
    send(32'h8000_0000);
    send(32'h1234_5678);
    repeat (6) @(negedge CLK);

    // Stall 10 cycles in WAIT_DATA between two frames
    exp_strobe(32'h0000_0004, 32'hCAFE_0001, 0, 1'b1);
    exp_strobe(32'h0000_0008, 32'hCAFE_0002, 0, 1'b1);
    done_q.push_back(1'b0);
    send(32'h8000_0102);
    send(32'hCAFE_0001);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      chk("stall_busy", {31'h0, busy}, 32'h1);
      chk("stall_strobe", FrameStrobe, 32'h0);
      @(negedge CLK);
    end
    send(32'hCAFE_0002);
    repeat (6) @(negedge CLK);

    // Reset during the STROBE cycle of frame 3 of a 4-frame burst
    exp_strobe(32'h0000_0001, 32'hBEEF_0001, 0, 1'b1);
    exp_strobe(32'h0000_0002, 32'hBEEF_0002, 4, 1'b1);
    exp_strobe(32'h0000_0004, 32'hBEEF_0003, 4, 1'b0);
    send(32'h8000_0300);
    send(32'hBEEF_0001);
    send(32'hBEEF_0002);
    send(32'hBEEF_0003);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("midrst_strobe", FrameStrobe, 32'h0);
    chk("midrst_data", FrameData, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_ready", {31'h0, s_ready}, 32'h0);
    reset = 1'b0;
    @(negedge CLK);
    chk("midrst_ready_after", {31'h0, s_ready}, 32'h1);
    repeat (5) @(negedge CLK);

    chk("strobes_pending", 32'(exp_q.size()), 32'h0);
    chk("done_pending", 32'(done_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 The block SHALL have parameter MaxFramesPerCol, default 32, giving the number of frame strobes per column (legal range 2..256).
REQ-002 The block SHALL have parameter FrameBitsPerRow, default 32, giving the frame data width and stream word width (legal minimum 16).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port s_data, input, FrameBitsPerRow bits: stream word (address word or frame data word).
REQ-006 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-008 The block SHALL have port FrameData, output, FrameBitsPerRow bits: data bus to the column frame latches.
REQ-009 The block SHALL have port FrameStrobe, output, MaxFramesPerCol bits: one-hot latch enables.
REQ-010 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-012 The block SHALL have port err, output, 1 bit: sticky error flag.
REQ-013 The block SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-014 A word SHALL be transferred only on a rising edge where s_valid=1 and s_ready=1.
REQ-015 Address word format SHALL be: bit FrameBitsPerRow-1 = 1 (address marker); bits [15:8] = CNT, giving burst length N = CNT+1; bits [7:0] = IDX, the start frame.
REQ-016 The state set SHALL be IDLE, WAIT_DATA, SETUP, STROBE, HOLD and DISCARD.
REQ-017 s_ready SHALL be 1 in IDLE, WAIT_DATA and DISCARD, and 0 in SETUP, STROBE and HOLD.
REQ-018 IDLE, transfer with marker=1 and IDX+CNT <= MaxFramesPerCol-1: the block SHALL load frame pointer=IDX and remaining=N, then go to WAIT_DATA.
REQ-019 IDLE, transfer with marker=1 and IDX+CNT > MaxFramesPerCol-1: the block SHALL set err, load remaining=N, and go to DISCARD.
REQ-020 IDLE, transfer with marker=0: the block SHALL discard the word, set err, and stay in IDLE.
REQ-021 WAIT_DATA, transfer: the block SHALL register the word into FrameData and go to SETUP; the word is treated as data regardless of bit FrameBitsPerRow-1.
REQ-022 SETUP SHALL last 1 cycle with FrameStrobe=0 and FrameData stable.
REQ-023 STROBE SHALL last 1 cycle with FrameStrobe = one-hot at the frame pointer.
REQ-024 HOLD SHALL last 1 cycle with FrameStrobe=0 and FrameData unchanged; on exit the block SHALL decrement remaining and increment the pointer.
REQ-025 Leaving HOLD with remaining>0 after decrement, the block SHALL go to WAIT_DATA; otherwise it SHALL pulse done for 1 cycle and go to IDLE.
REQ-026 FrameStrobe, FrameData and done SHALL be registered outputs; FrameStrobe SHALL never have more than one bit set.
REQ-027 Latency: data word accepted at edge k SHALL give FrameData valid from k; SETUP in cycle k..k+1; FrameStrobe asserted for exactly cycle k+1..k+2; HOLD in cycle k+2..k+3; next acceptance no earlier than edge k+3. Throughput is 1 frame per 4 cycles with continuous s_valid.
REQ-028 DISCARD SHALL consume N words with no FrameData or FrameStrobe change; after the Nth word it SHALL go to IDLE without a done pulse.
REQ-029 FrameData SHALL hold its last value in IDLE.
REQ-030 err SHALL be sticky until err_clr=1 or reset; if err_clr and a new error occur in the same cycle, err SHALL be 1 (set wins).
REQ-031 s_valid=0 in WAIT_DATA or DISCARD SHALL stall indefinitely, with outputs held and no timeout.

Reset
REQ-032 With reset=1 at an edge, the block SHALL set state=IDLE, FrameStrobe=0, FrameData=0, done=0, err=0, busy=0 and s_ready=0 in the reset cycle, with s_ready=1 from the first cycle after reset deasserts.
REQ-033 Reset mid-burst, including during STROBE, SHALL drop FrameStrobe to 0 at that edge and abandon the burst with no done pulse.

Verification
REQ-034 Single frame: addr 0x80000005, data 0xDEADBEEF -> FrameStrobe=0x00000020 for exactly 1 cycle, FrameData=0xDEADBEEF from 1 cycle before to 1 cycle after the strobe, done pulse, err=0.
REQ-035 Burst: addr 0x8000021D (IDX=29, N=3), data A, B, C with continuous valid -> strobes on bits 29, 30, 31 in order, 4 cycles apart, each with its matching data; one done pulse.
REQ-036 Overrun: addr 0x8000011F (IDX=31, N=2) -> err=1, 2 data words consumed, FrameStrobe stays 0, no done; err_clr then gives err=0.
REQ-037 Non-address word 0x00001234 in IDLE -> discarded, err=1, state stays IDLE; a following valid burst executes normally.
REQ-038 Reset asserted in the STROBE cycle of frame 3 -> FrameStrobe=0 and FrameData=0 at the next edge, no done pulse, busy=0.
REQ-039 Stall: s_valid deasserted for 10 cycles in WAIT_DATA -> FrameStrobe=0 throughout, busy=1, burst resumes correctly.
